datapath_pipe: RTL

Parametrised successor to the single-issue ARM32 datapath. It contains:
- An NREGS x DATA_W register file with two write ports.
- A, B and S operand latches with per-operand forwarding muxes.
- A barrel shifter with four shift types.
- An 8-op ALU.
- A registered result stage (C) and an NZCV status register.
It sits between the controller/decoder and data memory. Result latency is one explicit register stage.

---
 rtl/datapath_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/datapath_pipe.sv
// Parametrised ARM32-style datapath: dual-write register file with bypass, operand
// latches with forwarding, barrel shifter, 8-op ALU, registered result and NZCV flags.
module datapath_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     w_addr1,
  input  logic [DATA_W-1:0] w_data1,
  input  logic              w_en1,
  input  logic [AW-1:0]     w_addr2,
  input  logic              w_en2,
  input  logic [AW-1:0]     A_addr,
  input  logic [AW-1:0]     B_addr,
  input  logic [AW-1:0]     shift_addr,
  input  logic [1:0]        sel_A_in,
  input  logic [1:0]        sel_B_in,
  input  logic [1:0]        sel_shift_in,
  input  logic              en_A,
  input  logic              en_B,
  input  logic              en_S,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] shift_imme,
  input  logic              sel_shift,
  input  logic [1:0]        shift_op,
  input  logic              sel_A,
  input  logic              sel_B,
  input  logic [DATA_W-1:0] imme_data,
  input  logic              sel_post_shift,
  input  logic [2:0]        ALU_op,
  input  logic              en_C,
  input  logic              en_status,
  output logic [DATA_W-1:0] datapath_out,
  output logic [31:0]       status_out
);

  localparam int SHW = $clog2(DATA_W) + 1;
  localparam int MSB = DATA_W - 1;
  localparam logic [SHW-1:0] DW_AMT = SHW'(DATA_W);
  localparam logic [DATA_W:0] ONE   = (DATA_W+1)'(1);

  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_op_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_ORR = 3'b011,
    OP_EOR = 3'b100, OP_MOV = 3'b101, OP_MVN = 3'b110, OP_RSB = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a, r_b, r_s, r_c;
  logic              r_flag_n, r_flag_z, r_flag_c, r_flag_v;

  logic [DATA_W-1:0] w_wb2;
  logic [DATA_W-1:0] w_rd_a, w_rd_b, w_rd_s;
  logic [SHW-1:0]    w_amt, w_ror_amt;
  logic [DATA_W:0]   w_lsl, w_lsr, w_asr;
  logic [DATA_W-1:0] w_ror;
  logic [DATA_W-1:0] w_sh_out;
  logic              w_sh_carry;
  logic [DATA_W-1:0] w_aop, w_bop, w_alu_res;
  logic [DATA_W:0]   w_sum, w_dif, w_rsb;
  logic              w_alu_c, w_alu_v;
  logic              w_unused_bits;

  function automatic logic [DATA_W-1:0] src_mux(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] wd1,
                                                input logic [DATA_W-1:0] c,
                                                input logic [DATA_W-1:0] pc);
    unique case (sel)
      2'b00:   return rf;
      2'b01:   return wd1;
      2'b10:   return c;
      default: return pc;
    endcase
  endfunction

  // Write-through reads: port 1 is checked first so its priority matches the array write.
  assign w_rd_a = (w_en1 && w_addr1 == A_addr) ? w_data1 :
                  (w_en2 && w_addr2 == A_addr) ? w_wb2 : r_regs[A_addr];
  assign w_rd_b = (w_en1 && w_addr1 == B_addr) ? w_data1 :
                  (w_en2 && w_addr2 == B_addr) ? w_wb2 : r_regs[B_addr];
  assign w_rd_s = (w_en1 && w_addr1 == shift_addr) ? w_data1 :
                  (w_en2 && w_addr2 == shift_addr) ? w_wb2 : r_regs[shift_addr];

  assign w_amt         = sel_shift ? r_s[SHW-1:0] : shift_imme[SHW-1:0];
  assign w_unused_bits = ^{r_s[DATA_W-1:SHW], shift_imme[DATA_W-1:SHW]};

  // Each shift is done one bit wider so the carry falls out as the extra bit,
  // which also yields the right carry for amounts equal to DATA_W.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_sh_out   = r_b;
    w_sh_carry = r_flag_c;
    w_lsl      = {1'b0, r_b} << w_amt;
    w_lsr      = {r_b, 1'b0} >> w_amt;
    w_asr      = $signed({r_b, 1'b0}) >>> w_amt;
    w_ror_amt  = w_amt % DW_AMT;
    w_ror      = DATA_W'({r_b, r_b} >> w_ror_amt);
    if (w_amt != '0) begin
      unique case (shift_op_e'(shift_op))
        SH_LSL: begin w_sh_out = w_lsl[DATA_W-1:0]; w_sh_carry = w_lsl[DATA_W]; end
        SH_LSR: begin w_sh_out = w_lsr[DATA_W:1];   w_sh_carry = w_lsr[0];      end
        SH_ASR: begin w_sh_out = w_asr[DATA_W:1];   w_sh_carry = w_asr[0];      end
        SH_ROR: begin w_sh_out = w_ror;             w_sh_carry = w_ror[MSB];    end
      endcase
    end
  end

  assign w_aop = sel_A ? '0 : r_a;
  assign w_bop = sel_B ? imme_data : (sel_post_shift ? r_b : w_sh_out);
  assign w_sum = {1'b0, w_aop} + {1'b0, w_bop};
  assign w_dif = {1'b0, w_aop} + {1'b0, ~w_bop} + ONE;
  assign w_rsb = {1'b0, w_bop} + {1'b0, ~w_aop} + ONE;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = w_sh_carry;
    w_alu_v   = r_flag_v;
    unique case (alu_op_e'(ALU_op))
      OP_ADD: begin
        w_alu_res = w_sum[MSB:0];
        w_alu_c   = w_sum[DATA_W];
        w_alu_v   = (w_aop[MSB] == w_bop[MSB]) && (w_sum[MSB] != w_aop[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_dif[MSB:0];
        w_alu_c   = w_dif[DATA_W];
        w_alu_v   = (w_aop[MSB] != w_bop[MSB]) && (w_dif[MSB] != w_aop[MSB]);
      end
      OP_RSB: begin
        w_alu_res = w_rsb[MSB:0];
        w_alu_c   = w_rsb[DATA_W];
        w_alu_v   = (w_bop[MSB] != w_aop[MSB]) && (w_rsb[MSB] != w_bop[MSB]);
      end
      OP_AND: w_alu_res = w_aop & w_bop;
      OP_ORR: w_alu_res = w_aop | w_bop;
      OP_EOR: w_alu_res = w_aop ^ w_bop;
      OP_MOV: w_alu_res = w_bop;
      OP_MVN: w_alu_res = ~w_bop;
    endcase
  end

  assign w_wb2 = sel_post_shift ? w_sh_out : w_alu_res;

  // NOTE: the register file must clear on reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: non-blocking writes; the later port-1 assignment overrides port 2 on an address clash.
      if (w_en2) r_regs[w_addr2] <= w_wb2;
      if (w_en1) r_regs[w_addr1] <= w_data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_c      <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else begin
      if (en_A) r_a <= src_mux(sel_A_in, w_rd_a, w_data1, r_c, PC);
      if (en_B) r_b <= src_mux(sel_B_in, w_rd_b, w_data1, r_c, PC);
      if (en_S) r_s <= src_mux(sel_shift_in, w_rd_s, w_data1, r_c, PC);
      if (en_C) r_c <= w_alu_res;
      if (en_status) begin
        r_flag_n <= w_alu_res[MSB];
        r_flag_z <= (w_alu_res == '0);
        r_flag_c <= w_alu_c;
        r_flag_v <= w_alu_v;
      end
    end
  end

  assign datapath_out = r_c;
  assign status_out   = {r_flag_n, r_flag_z, r_flag_c, r_flag_v, 28'b0};

endmodule
